weight_feeder: RTL

- Downstream consumer of weight_ram. It sequences read addresses into the RAM's registered read port.
- It unpacks each returned word into ROWS lanes of DATA_W bits.
- It applies a diagonal skew (lane r delayed r cycles) so weights enter systolic array rows staggered.
- A start/busy/done handshake lets the controller launch a burst of len_i consecutive words from base_addr_i.

---
 rtl/weight_feeder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/weight_feeder.sv
// Burst reader for weight_ram: issues consecutive read addresses, unpacks each word
// into ROWS lanes and skews lane r by r cycles for systolic-array row feeding.
module weight_feeder #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic [ADDR_W:0]          len_i,
    input  logic                     stall_i,
    output logic [ADDR_W-1:0]        ram_addr_o,
    output logic                     ram_rd_en_o,
    input  logic [ROWS*DATA_W-1:0]   ram_data_i,
    output logic [ROWS*DATA_W-1:0]   w_data_o,
    output logic [ROWS-1:0]          w_valid_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int WW = ROWS * DATA_W;
    localparam int CW = ADDR_W + 1;
    localparam int DW = $clog2(ROWS + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CW-1:0]     len_q, len_d;
    logic [CW-1:0]     k_q, k_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [CW-1:0]     addr_sum;

    logic              issued_q;
    logic              stall_q;
    logic [WW-1:0]     hold_q;
    logic [WW-1:0]     word_eff;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        k_d         = k_q;
        drain_d     = drain_q;
        ram_rd_en_o = 1'b0;
        ram_addr_o  = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        addr_sum = CW'(base_q) + k_q;
        if (addr_sum >= CW'(DEPTH)) begin
            addr_sum = addr_sum - CW'(DEPTH);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !stall_i) begin
                    if (len_i != '0) begin
                        base_d  = base_addr_i;
                        len_d   = len_i;
                        k_d     = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                busy_o      = 1'b1;
                ram_rd_en_o = 1'b1;
                ram_addr_o  = addr_sum[ADDR_W-1:0];
                if (!stall_i) begin
                    k_d = k_q + CW'(1);
                    if (k_q == len_q - CW'(1)) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (!stall_i) begin
                    if (drain_q == DW'(ROWS)) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = !stall_i;
                if (!stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The RAM keeps registering every edge, so the word returned on the first stalled
    // cycle is parked in hold_q; later stalled cycles would otherwise read ahead.
    always_comb begin
        word_eff = stall_q ? hold_q : ram_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q  <= 1'b0;
            hold_q   <= '0;
            issued_q <= 1'b0;
        end else begin
            stall_q <= stall_i;
            hold_q  <= word_eff;
            if (!stall_i) begin
                issued_q <= (state_q == ST_ISSUE);
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_W-1:0] pipe_q [0:r];
        logic [r:0]        vld_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                vld_q <= '0;
                for (int unsigned j = 0; j <= unsigned'(r); j++) begin
                    pipe_q[j] <= '0;
                end
            end else if (!stall_i) begin
                vld_q[0]  <= issued_q;
                pipe_q[0] <= issued_q ? word_eff[r*DATA_W +: DATA_W] : '0;
                for (int unsigned j = 1; j <= unsigned'(r); j++) begin
                    pipe_q[j] <= pipe_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        assign w_data_o[r*DATA_W +: DATA_W] = pipe_q[r];
        assign w_valid_o[r]                 = vld_q[r];
    end

endmodule
